ex_stage: RTL and testbench

- Execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered decode bundle (aluop, alusel, two 64-bit operands, writeback and memory controls) and produces the ALU result, memory address and forwarded controls for the EX/MEM register.
- Single-cycle ops complete combinationally.
- DIV/DIVU/REM/REMU run on an iterative 64-step restoring divider; a stall request holds the upstream pipeline until the divider finishes.

---
 rtl/ex_stage.sv | 207 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage -- execute stage fed by the ID/EX pipeline register.
//
// Computes the ALU result for LOGIC / SHIFT / ARITH ops combinationally and
// runs DIV/DIVU/REM/REMU on an iterative restoring divider that produces one
// quotient bit per cycle. While the divider is busy, stall_req_o holds
// ID/EX and everything upstream of it.
//
// Optional feature: define EX_MUL_EN to enable MUL (aluop 0x0C, class ARITH).
// Without it, 0x0C is an unknown op and no multiplier is built.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush_i               kill the in-flight instruction
//   aluop_i, alusel_i     operation code / operation class
//   oprand1_i, oprand2_i  source operands
//   reg_write_*_i         writeback controls from decode
//   mem_valid_i, mem_rw_i memory controls from decode
//   reg_write_*_o         result and gated writeback controls
//   mem_valid_o, mem_rw_o gated memory request / forwarded direction
//   mem_addr_o            oprand1_i + oprand2_i
//   stall_req_o           divider busy, hold upstream
module ex_stage #(
    parameter int XLEN      = 64,
    parameter int DIV_CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [7:0]      aluop_i,
    input  logic [3:0]      alusel_i,
    input  logic [XLEN-1:0] oprand1_i,
    input  logic [XLEN-1:0] oprand2_i,
    input  logic [4:0]      reg_write_addr_i,
    input  logic            reg_write_enable_i,
    input  logic            mem_valid_i,
    input  logic            mem_rw_i,
    output logic [XLEN-1:0] reg_write_data_o,
    output logic [4:0]      reg_write_addr_o,
    output logic            reg_write_enable_o,
    output logic            mem_valid_o,
    output logic            mem_rw_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            stall_req_o
);
    localparam logic [3:0] SEL_NOP = 4'd0, SEL_LOGIC = 4'd1, SEL_SHIFT = 4'd2,
                           SEL_ARITH = 4'd3, SEL_DIV = 4'd4, SEL_MEM = 4'd5;
    localparam logic [7:0] OP_AND = 8'h01, OP_OR = 8'h02, OP_XOR = 8'h03,
                           OP_SLL = 8'h04, OP_SRL = 8'h05, OP_SRA = 8'h06,
                           OP_ADD = 8'h07, OP_SUB = 8'h08, OP_SLT = 8'h09,
                           OP_SLTU = 8'h0A, OP_MUL = 8'h0C, OP_DIV = 8'h10,
                           OP_DIVU = 8'h11, OP_REM = 8'h12, OP_REMU = 8'h13;
    localparam logic [XLEN-1:0]      MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(XLEN-1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;

    div_state_t           state, state_nx;
    logic [DIV_CNT_W-1:0] cnt;
    logic [XLEN-1:0]      dq;     // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]      dr;     // partial remainder
    logic [XLEN-1:0]      dd;     // divisor magnitude
    logic                 neg_q, neg_r, rem_sel;

    // ---------------- divider operand prep and one restoring step
    logic            is_div_op, div_signed, div_zero, div_ovf;
    logic [XLEN-1:0] op1_mag, op2_mag;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_next, r_next, div_res;

    assign is_div_op  = (alusel_i == SEL_DIV) &&
                        (aluop_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    assign div_signed = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
    assign op1_mag    = (div_signed && oprand1_i[XLEN-1]) ? -oprand1_i : oprand1_i;
    assign op2_mag    = (div_signed && oprand2_i[XLEN-1]) ? -oprand2_i : oprand2_i;
    assign div_zero   = (oprand2_i == '0);
    assign div_ovf    = div_signed && (oprand1_i == MIN_NEG) && (oprand2_i == '1);

    // One extra bit keeps the shifted remainder exact: it is always < 2*divisor.
    assign rem_sh  = {dr, dq[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dd};
    assign q_next  = {dq[XLEN-2:0], ~diff[XLEN]};
    assign r_next  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign div_res = rem_sel ? (neg_r ? -dr : dr) : (neg_q ? -dq : dq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            dq      <= '0;
            dr      <= '0;
            dd      <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (is_div_op && !flush_i) begin
                    rem_sel <= (aluop_i == OP_REM) || (aluop_i == OP_REMU);
                    cnt     <= '0;
                    dd      <= op2_mag;
                    // Special cases load final values directly, no sign fix-up.
                    if (div_zero) begin
                        dq    <= '1;
                        dr    <= oprand1_i;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (div_ovf) begin
                        dq    <= oprand1_i;
                        dr    <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        dq    <= op1_mag;
                        dr    <= '0;
                        neg_q <= div_signed && (oprand1_i[XLEN-1] ^ oprand2_i[XLEN-1]);
                        neg_r <= div_signed && oprand1_i[XLEN-1];
                    end
                end
                S_CALC: if (!flush_i) begin
                    dq  <= q_next;
                    dr  <= r_next;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- next state, ALU result and output gating
    logic [XLEN-1:0] result;
    logic            op_valid, stall;

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        result   = '0;
        op_valid = 1'b0;

        case (state)
            S_IDLE: if (is_div_op) begin
                stall    = 1'b1;
                state_nx = (div_zero || div_ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                stall = 1'b1;
                if (cnt == CNT_LAST) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase

        case (alusel_i)
            SEL_NOP, SEL_MEM: op_valid = 1'b1;
            SEL_LOGIC: begin
                op_valid = 1'b1;
                case (aluop_i)
                    OP_AND:  result = oprand1_i & oprand2_i;
                    OP_OR:   result = oprand1_i | oprand2_i;
                    OP_XOR:  result = oprand1_i ^ oprand2_i;
                    default: op_valid = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                op_valid = 1'b1;
                case (aluop_i)
                    OP_SLL:  result = oprand1_i << oprand2_i[5:0];
                    OP_SRL:  result = oprand1_i >> oprand2_i[5:0];
                    OP_SRA:  result = $unsigned($signed(oprand1_i) >>> oprand2_i[5:0]);
                    default: op_valid = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                op_valid = 1'b1;
                case (aluop_i)
                    OP_ADD:  result = oprand1_i + oprand2_i;
                    OP_SUB:  result = oprand1_i - oprand2_i;
                    OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(oprand1_i) < $signed(oprand2_i)};
                    OP_SLTU: result = {{(XLEN-1){1'b0}}, oprand1_i < oprand2_i};
`ifdef EX_MUL_EN
                    OP_MUL:  result = oprand1_i * oprand2_i;
`endif
                    default: op_valid = 1'b0;
                endcase
            end
            SEL_DIV: if (is_div_op && state == S_DONE) begin
                op_valid = 1'b1;
                result   = div_res;
            end
            default: op_valid = 1'b0;
        endcase

        // A flush wins over any divider progress and drops the stall.
        if (flush_i) begin
            state_nx = S_IDLE;
            stall    = 1'b0;
        end
    end

    assign reg_write_data_o   = rst ? '0 : result;
    assign reg_write_addr_o   = rst ? '0 : reg_write_addr_i;
    assign mem_rw_o           = !rst && mem_rw_i;
    assign mem_addr_o         = rst ? '0 : oprand1_i + oprand2_i;
    assign stall_req_o        = !rst && stall;
    assign reg_write_enable_o = !rst && !flush_i && !stall && op_valid && reg_write_enable_i;
    assign mem_valid_o        = !rst && !flush_i && !stall && op_valid && mem_valid_i;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge. Divider latency is measured by counting stalled cycles under a bound.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst, flush_i;
    logic [7:0]  aluop_i;
    logic [3:0]  alusel_i;
    logic [63:0] oprand1_i, oprand2_i;
    logic [4:0]  reg_write_addr_i;
    logic        reg_write_enable_i, mem_valid_i, mem_rw_i;
    logic [63:0] reg_write_data_o, mem_addr_o;
    logic [4:0]  reg_write_addr_o;
    logic        reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .oprand1_i(oprand1_i), .oprand2_i(oprand2_i),
        .reg_write_addr_i(reg_write_addr_i), .reg_write_enable_i(reg_write_enable_i),
        .mem_valid_i(mem_valid_i), .mem_rw_i(mem_rw_i),
        .reg_write_data_o(reg_write_data_o), .reg_write_addr_o(reg_write_addr_o),
        .reg_write_enable_o(reg_write_enable_o), .mem_valid_o(mem_valid_o),
        .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o), .stall_req_o(stall_req_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [7:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic we, input logic mv, input logic rw);
        alusel_i           = sel;
        aluop_i            = op;
        oprand1_i          = a;
        oprand2_i          = b;
        reg_write_addr_i   = 5'd5;
        reg_write_enable_i = we;
        mem_valid_i        = mv;
        mem_rw_i           = rw;
    endtask

    // Single-cycle op: result and gated controls in the same cycle, no stall.
    task automatic alu_chk(input string tag, input logic [3:0] sel, input logic [7:0] op,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_d, input logic exp_we);
        drive(sel, op, a, b, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk({tag, " data"}, reg_write_data_o, exp_d);
        chk({tag, " we"}, 64'(reg_write_enable_o), 64'(exp_we));
        chk({tag, " mv"}, 64'(mem_valid_o), 64'(exp_we));
        chk({tag, " stall"}, 64'(stall_req_o), 64'd0);
        step();
    endtask

    // Divide op: count stalled cycles (bounded), then check the DONE cycle.
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [63:0] a, input logic [63:0] b,
                           input int exp_cyc, input logic [63:0] exp_d);
        int n;
        int leak;
        drive(4'd4, op, a, b, 1'b1, 1'b1, 1'b0);
        n = 0;
        leak = 0;
        @(negedge clk);
        while (stall_req_o && n < 200) begin
            if (reg_write_enable_o || mem_valid_o) leak++;
            n++;
            step();
            @(negedge clk);
        end
        chk({tag, " stall cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, " leak"}, 64'(leak), 64'd0);
        chk({tag, " data"}, reg_write_data_o, exp_d);
        chk({tag, " we"}, 64'(reg_write_enable_o), 64'd1);
        chk({tag, " mv"}, 64'(mem_valid_o), 64'd1);
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        drive(4'd3, 8'h07, 64'h10, 64'h20, 1'b1, 1'b1, 1'b1);
        step();
        step();
        @(negedge clk);
        chk("rst data", reg_write_data_o, 64'd0);
        chk("rst addr", mem_addr_o, 64'd0);
        chk("rst ctrl", {59'd0, reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o,
                         1'b0}, 64'd0);
        chk("rst waddr", 64'(reg_write_addr_o), 64'd0);
        step();
        rst = 1'b0;

        // ADD wraps; controls forwarded same cycle
        drive(4'd3, 8'h07, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("add data", reg_write_data_o, 64'd1);
        chk("add we", 64'(reg_write_enable_o), 64'd1);
        chk("add waddr", 64'(reg_write_addr_o), 64'd5);
        chk("add stall", 64'(stall_req_o), 64'd0);
        chk("add maddr", mem_addr_o, 64'd1);
        step();

        alu_chk("and", 4'd1, 8'h01, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'hF000_F000_F000_F000, 1'b1);
        alu_chk("or", 4'd1, 8'h02, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'hFFF0_FFF0_FFF0_FFF0, 1'b1);
        alu_chk("xor", 4'd1, 8'h03, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h0FF0_0FF0_0FF0_0FF0, 1'b1);
        alu_chk("sll", 4'd2, 8'h04, 64'd1, 64'h44, 64'h10, 1'b1);
        alu_chk("srl", 4'd2, 8'h05, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b1);
        alu_chk("sra", 4'd2, 8'h06, 64'h8000_0000_0000_0000, 64'd4,
                64'hF800_0000_0000_0000, 1'b1);
        alu_chk("sub", 4'd3, 8'h08, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        alu_chk("slt", 4'd3, 8'h09, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b1);
        alu_chk("sltu", 4'd3, 8'h0A, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
        alu_chk("bad op", 4'd1, 8'h07, 64'd3, 64'd4, 64'd0, 1'b0);
        alu_chk("bad sel", 4'd7, 8'h01, 64'd3, 64'd4, 64'd0, 1'b0);
        alu_chk("nop", 4'd0, 8'h00, 64'd3, 64'd4, 64'd0, 1'b1);
`ifdef EX_MUL_EN
        alu_chk("mul", 4'd3, 8'h0C, 64'd3, 64'd5, 64'd15, 1'b1);
`else
        alu_chk("mul", 4'd3, 8'h0C, 64'd3, 64'd5, 64'd0, 1'b0);
`endif

        // MEM class: result 0, address is the sum, direction forwarded
        drive(4'd5, 8'h00, 64'h1000, 64'h20, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("mem data", reg_write_data_o, 64'd0);
        chk("mem addr", mem_addr_o, 64'h1020);
        chk("mem mv", 64'(mem_valid_o), 64'd1);
        chk("mem rw", 64'(mem_rw_o), 64'd1);
        step();

        // Divider
        run_div("div -7/2", 8'h10, -64'sd7, 64'd2, 65, -64'sd3);
        run_div("rem -7/2", 8'h12, -64'sd7, 64'd2, 65, -64'sd1);
        run_div("div 7/-2", 8'h10, 64'd7, -64'sd2, 65, -64'sd3);
        run_div("rem 7/-2", 8'h12, 64'd7, -64'sd2, 65, 64'd1);
        run_div("divu 100/7", 8'h11, 64'd100, 64'd7, 65, 64'd14);
        run_div("remu 100/7", 8'h13, 64'd100, 64'd7, 65, 64'd2);
        run_div("divu 9/0", 8'h11, 64'd9, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_div("remu 9/0", 8'h13, 64'd9, 64'd0, 1, 64'd9);
        run_div("rem -9/0", 8'h12, -64'sd9, 64'd0, 1, -64'sd9);
        run_div("div ovf", 8'h10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                64'h8000_0000_0000_0000);
        run_div("rem ovf", 8'h12, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                64'd0);

        // Flush at cycle 10 of a DIVU
        drive(4'd4, 8'h11, 64'd100, 64'd7, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step();
        @(negedge clk);
        chk("pre-flush stall", 64'(stall_req_o), 64'd1);
        step();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush stall", 64'(stall_req_o), 64'd0);
        chk("flush we", 64'(reg_write_enable_o), 64'd0);
        chk("flush mv", 64'(mem_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        drive(4'd0, 8'h00, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post-flush stall", 64'(stall_req_o), 64'd0);
        chk("post-flush we", 64'(reg_write_enable_o), 64'd1);
        step();

        // Reset at cycle 20 of a DIVU
        drive(4'd4, 8'h11, 64'd100, 64'd7, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst data", reg_write_data_o, 64'd0);
        chk("mid rst addr", mem_addr_o, 64'd0);
        chk("mid rst ctrl", {60'd0, reg_write_enable_o, mem_valid_o, mem_rw_o, stall_req_o},
            64'd0);
        step();
        rst = 1'b0;
        drive(4'd0, 8'h00, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post-rst stall", 64'(stall_req_o), 64'd0);
        step();
        run_div("divu after rst", 8'h11, 64'd100, 64'd7, 65, 64'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
